sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter ROM_LAT, default 2, sprite-ROM read latency in pixel_Clk cycles (range 1..7).
REQ-002 Parameter TRANSP, default 4'h0, palette index treated as transparent.
REQ-003 Parameter SCREEN_W, default 640, and SCREEN_H, default 480, framebuffer clip bounds.
REQ-004 pixel_Clk  in  1  sole clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to blit one sprite.
REQ-007 PosX, PosY  in  10 each  screen position of the sprite's top-left pixel.
REQ-008 base  in  18  sprite-ROM address of the sprite's first pixel (row-major).
REQ-009 SizeX, SizeY  in  8 each  sprite width and height in pixels.
REQ-010 rom_addr  out  18  sprite-ROM read address.
REQ-011 rom_data  in  4  palette index returned ROM_LAT cycles after rom_addr.
REQ-012 fb_we  out  1  framebuffer write request.
REQ-013 WriteX, WriteY  out  10 each  framebuffer write coordinates.
REQ-014 fb_data  out  4  palette index to write.
REQ-015 fb_ready  in  1  framebuffer accepts a write when fb_we and fb_ready are high on the same edge.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle pulse when a blit completes.

Function
REQ-018 States: IDLE, FETCH, WAIT, WRITE, DONE.
REQ-019 IDLE: on start=1, latch PosX, PosY, base, SizeX, SizeY, clear DistX=DistY=0, go FETCH; busy=0.
REQ-020 start while busy=1 is ignored; latched inputs do not change mid-blit.
REQ-021 Latched SizeX=0 or SizeY=0: go directly to DONE; no ROM reads, no fb_we.
REQ-022 FETCH: rom_addr = base + DistY*SizeX + DistX, modulo 2^18; held constant through WAIT; next state WAIT.
REQ-023 WAIT: lasts ROM_LAT cycles counted from the FETCH edge; at its last edge rom_data is registered into fb_data; next state WRITE.
REQ-024 WRITE: WriteX = PosX+DistX, WriteY = PosY+DistY, low 10 bits; sums are evaluated at 11 bits for clipping.
REQ-025 Pixel is skipped (fb_we stays 0, one WRITE cycle) when fb_data==TRANSP, 11-bit X sum >= SCREEN_W, or 11-bit Y sum >= SCREEN_H.
REQ-026 Non-skipped pixel: fb_we=1 with WriteX, WriteY, fb_data stable until the edge where fb_ready=1; fb_we drops the following cycle.
REQ-027 Advance after accept or skip: DistX+1; at DistX==SizeX-1, DistX=0 and DistY+1; at last pixel (SizeX-1, SizeY-1) go DONE, else FETCH.
REQ-028 DONE: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE; start in DONE is ignored.
REQ-029 Per-pixel cost with fb_ready=1: ROM_LAT+2 cycles; pixels are written strictly in row-major order.
REQ-030 fb_we never asserts outside WRITE; at most one accepted write per pixel.

Reset
REQ-031 Reset_n=0 asynchronously forces IDLE; fb_we, busy, done = 0; rom_addr, WriteX, WriteY, fb_data, DistX, DistY = 0.
REQ-032 Reset mid-blit abandons the blit with no done pulse; first clock edge after release stays IDLE unless start=1.

Verification
REQ-033 Pos=(100,50), base=207867, Size=88x94, ROM all 4'h5, fb_ready=1 -> 8272 writes, first (100,50) rom_addr 207867, last (187,143) rom_addr 216138, done once.
REQ-034 Size=2x2, base=0, ROM {0,3,0,7} -> exactly two writes: (PosX+1,PosY) data 3, (PosX+1,PosY+1) data 7.
REQ-035 Pos=(638,478), Size=4x4, opaque ROM -> only (638,478),(639,478),(638,479),(639,479) written; done after 16 pixels.
REQ-036 fb_ready held low 5 cycles on first opaque pixel -> fb_we high 6 cycles, outputs stable, no advance until accept.
REQ-037 SizeX=0 -> done pulse 2 cycles after start, no fb_we; start during busy -> ignored, single done.
REQ-038 Reset_n low during WAIT of pixel 10 -> outputs zero immediately, no done; new start then blits from pixel 0.

Source files
------------

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a rectangular sprite from a palette-index ROM into a
// framebuffer. Pixels go out in row-major order, with transparent and
// off-screen pixels dropped.
//
// Handshake: a framebuffer write completes on a rising edge where fb_we and
// fb_ready are both high. fb_we never drops before that edge. WriteX, WriteY
// and fb_data stay constant while fb_we waits for fb_ready.
module sprite_blitter #(
    parameter int unsigned ROM_LAT  = 2,
    parameter logic [3:0]  TRANSP   = 4'h0,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic        pixel_Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [9:0]  PosX,
    input  logic [9:0]  PosY,
    input  logic [17:0] base,
    input  logic [7:0]  SizeX,
    input  logic [7:0]  SizeY,
    output logic [17:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        fb_we,
    output logic [9:0]  WriteX,
    output logic [9:0]  WriteY,
    output logic [3:0]  fb_data,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0]  WAIT_LAST = 3'(ROM_LAT - 1);
    localparam logic [10:0] SCR_W     = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H     = 11'(SCREEN_H);

    state_t      state_q, state_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic [7:0]  size_x_q, size_x_d;
    logic [7:0]  size_y_q, size_y_d;
    logic [7:0]  dist_x_q, dist_x_d;
    logic [7:0]  dist_y_q, dist_y_d;
    logic [17:0] addr_q, addr_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  data_q, data_d;

    // Screen coordinates are kept at 11 bits so that a sprite running off the
    // right or bottom edge is clipped and does not wrap around to the far side.
    logic [10:0] sum_x, sum_y;
    logic        skip;

    assign sum_x = {1'b0, pos_x_q} + {3'b000, dist_x_q};
    assign sum_y = {1'b0, pos_y_q} + {3'b000, dist_y_q};
    assign skip  = (data_q == TRANSP) || (sum_x >= SCR_W) || (sum_y >= SCR_H);

    assign rom_addr    = addr_q;
    assign fb_data     = data_q;
    assign WriteX      = sum_x[9:0];
    assign WriteY      = sum_y[9:0];
    assign fb_we       = (state_q == S_WRITE) && !skip;
    assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

    // Next-state logic. Row-major order means each pixel's ROM address is
    // one more than the previous pixel's address.
    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        dist_x_d = dist_x_q;
        dist_y_d = dist_y_q;
        addr_d   = addr_q;
        wait_d   = wait_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_x_d  = PosX;
                    pos_y_d  = PosY;
                    size_x_d = SizeX;
                    size_y_d = SizeY;
                    dist_x_d = 8'd0;
                    dist_y_d = 8'd0;
                    addr_d   = base;
                    state_d  = ((SizeX == 8'd0) || (SizeY == 8'd0)) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                wait_d  = WAIT_LAST;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 3'd0) begin
                    data_d  = rom_data;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_WRITE: begin
                if (skip || fb_ready) begin
                    addr_d = addr_q + 18'd1;
                    if (dist_x_q == size_x_q - 8'd1) begin
                        dist_x_d = 8'd0;
                        if (dist_y_q == size_y_q - 8'd1) begin
                            state_d = S_DONE;
                        end else begin
                            dist_y_d = dist_y_q + 8'd1;
                            state_d  = S_FETCH;
                        end
                    end else begin
                        dist_x_d = dist_x_q + 8'd1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any blit in progress and clears every output.
    always_ff @(posedge pixel_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            size_x_q <= '0;
            size_y_q <= '0;
            dist_x_q <= '0;
            dist_y_q <= '0;
            addr_q   <= '0;
            wait_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            dist_x_q <= dist_x_d;
            dist_y_q <= dist_y_d;
            addr_q   <= addr_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter. It has a ROM model with fixed read latency,
// a framebuffer port with configurable backpressure, and a reference model
// that lists the expected writes for each blit.
module tb_sprite_blitter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  pos_x, pos_y;
    logic [17:0] base;
    logic [7:0]  size_x, size_y;
    logic [17:0] rom_addr;
    logic [3:0]  rom_data;
    logic        fb_we;
    logic [9:0]  write_x, write_y;
    logic [3:0]  fb_data;
    logic        fb_ready;
    logic        busy, done;
    logic [2:0]  dbg_state;

    sprite_blitter #(.ROM_LAT(LAT)) dut (
        .pixel_Clk   (clk),
        .Reset_n     (rst_n),
        .start       (start),
        .PosX        (pos_x),
        .PosY        (pos_y),
        .base        (base),
        .SizeX       (size_x),
        .SizeY       (size_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fb_we       (fb_we),
        .WriteX      (write_x),
        .WriteY      (write_y),
        .fb_data     (fb_data),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // ROM model: data appears LAT cycles after the address is presented.
    logic [3:0] mem [0:262143];
    logic [3:0] rom_pipe [0:LAT-1];
    always @(posedge clk) begin
        rom_pipe[0] <= mem[rom_addr];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    // Scoreboard state
    logic [23:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int we_cycles = 0;
    int rdy_mode = 1;   // 0 manual, 1 always ready, 2 random

    // Framebuffer ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) fb_ready = 1'b1;
            else if (rdy_mode == 2) fb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the expected queue on every accepted write.
    always @(negedge clk) begin
        logic [23:0] got, exp;
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                n_vec++;
                if (busy) begin
                    n_err++;
                    $display("FAIL done_busy: busy=%0b required 0", busy);
                end
            end
            if (fb_we) begin
                we_cycles++;
                n_vec++;
                if (!busy) begin
                    n_err++;
                    $display("FAIL we_outside_blit: busy=%0b required 1", busy);
                end
                if (fb_ready) begin
                    got = {write_x, write_y, fb_data};
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_write: got x=%0d y=%0d d=%0h, required no write",
                                 write_x, write_y, fb_data);
                    end else begin
                        exp = exp_q.pop_front();
                        wr_cnt++;
                        if (got !== exp) begin
                            n_err++;
                            $display("FAIL write: got x=%0d y=%0d d=%0h, required x=%0d y=%0d d=%0h",
                                     got[23:14], got[13:4], got[3:0], exp[23:14], exp[13:4], exp[3:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic fill_const(input logic [3:0] v);
        for (int a = 0; a < 262144; a++) mem[a] = v;
    endtask

    task automatic fill_rand(input int lo);
        for (int a = 0; a < 262144; a++) mem[a] = 4'($urandom_range(lo, 15));
    endtask

    // Reference model: every sprite pixel in row-major order, keeping the
    // opaque ones whose 11-bit screen position is on screen.
    task automatic push_expected(input int px, input int py, input int b, input int sx, input int sy);
        int a, xs, ys;
        logic [3:0] d;
        for (int y = 0; y < sy; y++) begin
            for (int x = 0; x < sx; x++) begin
                a  = (b + y * sx + x) % 262144;
                d  = mem[a];
                xs = px + x;
                ys = py + y;
                if (d != 4'h0 && xs < 640 && ys < 480)
                    exp_q.push_back({10'(xs), 10'(ys), d});
            end
        end
    endtask

    // Driver: load the model, then pulse start for one cycle.
    task automatic start_blit(input int px, input int py, input int b, input int sx, input int sy);
        push_expected(px, py, b, sx, sy);
        @(posedge clk);
        #1;
        pos_x  = 10'(px);
        pos_y  = 10'(py);
        base   = 18'(b);
        size_x = 8'(sx);
        size_y = 8'(sy);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name, output int cyc);
        cyc = 0;
        while (done_cnt == d0 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        repeat (3) @(negedge clk);
        #1;
        check({name, "_done_count"}, done_cnt - d0, 1);
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_blit(input int px, input int py, input int b, input int sx, input int sy,
                            input int budget, input string name, output int cyc);
        int d0;
        d0 = done_cnt;
        start_blit(px, py, b, sx, sy);
        wait_done(d0, budget, name, cyc);
    endtask

    initial begin
        int cyc, d0, w0, we0, n;
        int px, py, b, sx, sy;
        logic [23:0] cap;
        logic stable;

        rst_n = 1'b0; start = 1'b0; pos_x = '0; pos_y = '0; base = '0;
        size_x = '0; size_y = '0; fb_ready = 1'b1;
        fill_const(4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_write_x", int'(write_x), 0);
        check("rst_write_y", int'(write_y), 0);
        check("rst_fb_data", int'(fb_data), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_release", int'(busy), 0);

        // Transparent pixels skipped
        fill_const(4'h0);
        mem[0] = 4'h0; mem[1] = 4'h3; mem[2] = 4'h0; mem[3] = 4'h7;
        w0 = wr_cnt;
        run_blit(30, 40, 0, 2, 2, 100, "blit2x2", cyc);
        check("blit2x2_writes", wr_cnt - w0, 2);

        // Clipping at the bottom-right corner, plus per-pixel cost
        fill_rand(1);
        w0 = wr_cnt;
        run_blit(638, 478, 1000, 4, 4, 200, "clip", cyc);
        check("clip_writes", wr_cnt - w0, 4);
        check("clip_cycles", cyc, 16 * (LAT + 2) + 1);

        // Backpressure: fb_ready held low for 5 cycles
        rdy_mode = 0;
        fb_ready = 1'b0;
        we0 = we_cycles;
        d0 = done_cnt;
        start_blit(5, 5, 100, 1, 1);
        n = 0;
        while (!fb_we && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        cap = {write_x, write_y, fb_data};
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if ({write_x, write_y, fb_data} !== cap || !fb_we) stable = 1'b0;
        end
        @(posedge clk);
        #1;
        fb_ready = 1'b1;
        rdy_mode = 1;
        wait_done(d0, 50, "stall", cyc);
        check("stall_we_cycles", we_cycles - we0, 6);
        check("stall_stable", int'(stable), 1);

        // Zero-width sprite
        we0 = we_cycles;
        d0 = done_cnt;
        start_blit(10, 10, 0, 0, 5);
        wait_done(d0, 4, "zero", cyc);
        check("zero_no_we", we_cycles - we0, 0);

        // A start pulse during a blit is ignored
        fill_rand(1);
        d0 = done_cnt;
        start_blit(200, 100, 5000, 3, 3);
        repeat (5) @(posedge clk);
        #1;
        pos_x = 10'd7; pos_y = 10'd7; base = 18'd9; size_x = 8'd2; size_y = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, 100, "busy_start", cyc);
        repeat (20) @(negedge clk);
        #1;
        check("busy_start_single_done", done_cnt - d0, 1);

        // Reset during the ROM wait of pixel 10
        d0 = done_cnt;
        w0 = wr_cnt;
        start_blit(50, 60, 300, 5, 5);
        n = 0;
        while (wr_cnt - w0 < 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_fb_we", int'(fb_we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rom_addr", int'(rom_addr), 0);
        check("midrst_write_x", int'(write_x), 0);
        check("midrst_write_y", int'(write_y), 0);
        check("midrst_fb_data", int'(fb_data), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", int'(busy), 0);
        w0 = wr_cnt;
        run_blit(50, 60, 300, 5, 5, 200, "after_rst", cyc);
        check("after_rst_writes", wr_cnt - w0, 25);

        // Randomized blits with random backpressure
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            fill_rand(0);
            px = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(620, 700));
            py = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(465, 520));
            b  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 262143)) : int'($urandom_range(262100, 262143));
            sx = $urandom_range(1, 10);
            sy = $urandom_range(1, 10);
            run_blit(px, py, b, sx, sy, sx * sy * 20 + 20, "rand", cyc);
        end
        rdy_mode = 1;

        // Large sprite with the base address near the top of the ROM
        fill_const(4'h5);
        w0 = wr_cnt;
        run_blit(100, 50, 207867, 88, 94, 34000, "big", cyc);
        check("big_writes", wr_cnt - w0, 8272);
        check("big_cycles", cyc, 8272 * (LAT + 2) + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
